// File: rtl/ags_accumulator.sv
// AGS stage: accumulates NUM_CORE_V partial-sum beats per pass, then derives one hidden bit per neuron serially.
// Define AGS_STOCHASTIC_EN for LFSR-sampled sigmoid outputs; the default build uses a strict acc > 0 threshold.
module ags_accumulator #(
  parameter int NUM_CORE_V     = 10,
  parameter int NUM_HN_ONECORE = 4,
  parameter int BW_PS          = 16,
  parameter int BW_ACC         = 20,
  parameter int SIG_SHIFT      = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic                             data_in_en,
  input  logic [BW_PS*NUM_HN_ONECORE-1:0]  data_in,
  output logic                             busy,
  output logic [BW_ACC*NUM_HN_ONECORE-1:0] acc_out,
  output logic [NUM_HN_ONECORE-1:0]        h_out,
  output logic                             h_valid,
  output logic                             drop_err
);

  localparam int BCW = $clog2(NUM_CORE_V + 1);
  localparam int KW  = (NUM_HN_ONECORE > 1) ? $clog2(NUM_HN_ONECORE) : 1;
  localparam int KCW = KW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, ACTIVATE} state_t;

  state_t                     state, state_nx;
  logic signed [BW_ACC-1:0]   acc [NUM_HN_ONECORE];
  logic [BCW-1:0]             beat_cnt;
  logic [KCW-1:0]             k;
  logic [KW-1:0]              kidx;
  logic [NUM_HN_ONECORE-1:0]  shadow;
  logic signed [BW_ACC-1:0]   acc_sel;
  logic                       beat_last;
  logic                       act_done;
  logic                       h_bit;

  assign kidx      = k[KW-1:0];
  assign acc_sel   = acc[kidx];
  assign beat_last = (state == ACCUM) && data_in_en && (beat_cnt == BCW'(NUM_CORE_V - 1));
  // k runs one past the last neuron: that extra cycle publishes h_out, giving the t+N+1 latency
  assign act_done  = (state == ACTIVATE) && (k == KCW'(NUM_HN_ONECORE));
  assign busy      = (state != IDLE);

  always_comb begin
    for (int unsigned i = 0; i < NUM_HN_ONECORE; i++)
      acc_out[BW_ACC*i +: BW_ACC] = acc[i];
  end

`ifdef AGS_STOCHASTIC_EN
  logic [7:0]               lfsr;
  logic signed [BW_ACC-1:0] acc_sh;
  logic signed [BW_ACC:0]   p_sum;
  logic [7:0]               p;

  always_comb begin
    acc_sh = acc_sel >>> SIG_SHIFT;
    p_sum  = {acc_sh[BW_ACC-1], acc_sh} + (BW_ACC+1)'(128);
    p      = p_sum[7:0];
    if (p_sum[BW_ACC])
      p = '0;
    else if (|p_sum[BW_ACC-1:8])
      p = '1;
    h_bit = (p >= lfsr);
  end

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 8'h01;
    else if (en && state == ACTIVATE && !act_done)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign h_bit = !acc_sel[BW_ACC-1] && (|acc_sel);
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (en) begin
      case (state)
        IDLE:     if (start)     state_nx = ACCUM;
        ACCUM:    if (beat_last) state_nx = ACTIVATE;
        ACTIVATE: if (act_done)  state_nx = IDLE;
        default:                 state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_HN_ONECORE; i++)
        acc[i] <= '0;
      beat_cnt <= '0;
      k        <= '0;
      shadow   <= '0;
      h_out    <= '0;
      h_valid  <= 1'b0;
      drop_err <= 1'b0;
    end else if (en) begin
      h_valid <= 1'b0;
      if (data_in_en && state != ACCUM)
        drop_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_HN_ONECORE; i++)
              acc[i] <= '0;
            beat_cnt <= '0;
            k        <= '0;
          end
        end
        ACCUM: begin
          if (data_in_en) begin
            for (int unsigned i = 0; i < NUM_HN_ONECORE; i++)
              acc[i] <= acc[i] + {{(BW_ACC-BW_PS){data_in[BW_PS*i+BW_PS-1]}},
                                  data_in[BW_PS*i +: BW_PS]};
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        ACTIVATE: begin
          if (act_done) begin
            h_out   <= shadow;
            h_valid <= 1'b1;
          end else begin
            shadow[kidx] <= h_bit;
            k            <= k + KCW'(1);
          end
        end
        default: ;
      endcase
    end else begin
      h_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ags_accumulator.sv
// Directed bench for ags_accumulator: table of full passes plus reset, drop and abort sequences.
module tb_ags_accumulator;

  localparam int NC = 10;
  localparam int NH = 4;
  localparam int BP = 16;
  localparam int BA = 20;

  logic            clk;
  logic            rst;
  logic            en;
  logic            start;
  logic            data_in_en;
  logic [BP*NH-1:0] data_in;
  logic            busy;
  logic [BA*NH-1:0] acc_out;
  logic [NH-1:0]   h_out;
  logic            h_valid;
  logic            drop_err;

  ags_accumulator #(
    .NUM_CORE_V(NC),
    .NUM_HN_ONECORE(NH),
    .BW_PS(BP),
    .BW_ACC(BA),
    .SIG_SHIFT(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .start(start),
    .data_in_en(data_in_en),
    .data_in(data_in),
    .busy(busy),
    .acc_out(acc_out),
    .h_out(h_out),
    .h_valid(h_valid),
    .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] beat;
    logic [79:0] acc;
    logic [3:0]  h;
    logic [3:0]  hmask;
    int          gap;
  } vec_t;

  localparam logic [63:0] B_MIX  = 64'h0001_0000_FFFD_0003;
  localparam logic [79:0] A_MIX  = {20'h0000A, 20'h00000, 20'hFFFE2, 20'h0001E};
  localparam logic [63:0] B_EXT  = 64'h0000_0000_8000_7FFF;
  localparam logic [79:0] A_EXT  = {20'h00000, 20'h00000, 20'hB0000, 20'h4FFF6};
  localparam logic [63:0] B_ONE  = 64'h0001_0001_0001_0001;
  localparam logic [79:0] A_ONE  = {4{20'h0000A}};
  localparam logic [63:0] B_NEG  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] A_NEG  = {4{20'hFFFF6}};
`ifdef AGS_STOCHASTIC_EN
  localparam logic [3:0] M_ALL = 4'b0000;
`else
  localparam logic [3:0] M_ALL = 4'b1111;
`endif

  vec_t vecs[6];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int already, input string tag);
    int  cyc;
    logic seen;
    cyc  = already;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      seen = h_valid;
    end
    check({tag, ".latency"}, 80'(cyc), 80'd5);
  endtask

  task automatic run_pass(input logic [63:0] beat, input logic [79:0] exp_acc,
                          input logic [3:0] exp_h, input logic [3:0] mask,
                          input int gap, input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < NC; b++) begin
      if (gap == 1 && (b % 2) == 1)
        tick();
      if (gap == 2 && (b % 3) == 0) begin
        en = 1'b0;
        data_in_en = 1'b1;
        data_in = beat;
        tick();
        tick();
        en = 1'b1;
        data_in_en = 1'b0;
      end
      data_in_en = 1'b1;
      data_in = beat;
      tick();
      data_in_en = 1'b0;
    end
    wait_valid(0, tag);
    check({tag, ".busy"}, 80'(busy), 80'd0);
    check({tag, ".acc"}, acc_out, exp_acc);
    check({tag, ".h"}, 80'(h_out & mask), 80'(exp_h & mask));
    tick();
    check({tag, ".pulse"}, 80'(h_valid), 80'd0);
    check({tag, ".acc_hold"}, acc_out, exp_acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{B_MIX, A_MIX, 4'b1001, M_ALL,   0};
    vecs[1] = '{B_MIX, A_MIX, 4'b1001, M_ALL,   1};
    vecs[2] = '{B_MIX, A_MIX, 4'b1001, M_ALL,   2};
    vecs[3] = '{B_EXT, A_EXT, 4'b0001, 4'b0011, 0};
    vecs[4] = '{B_ONE, A_ONE, 4'b1111, M_ALL,   1};
    vecs[5] = '{B_NEG, A_NEG, 4'b0000, M_ALL,   0};

    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    data_in_en = 1'b0;
    data_in = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset.busy", 80'(busy), 80'd0);
    check("reset.h_out", 80'(h_out), 80'd0);
    check("reset.h_valid", 80'(h_valid), 80'd0);
    check("reset.drop_err", 80'(drop_err), 80'd0);
    check("reset.acc", acc_out, 80'd0);

    for (int v = 0; v < 6; v++)
      run_pass(vecs[v].beat, vecs[v].acc, vecs[v].h, vecs[v].hmask, vecs[v].gap,
               $sformatf("vec%0d", v));
    check("vec.drop_err", 80'(drop_err), 80'd0);

    // beat coincident with start is dropped; beats during activation too
    data_in_en = 1'b1;
    data_in = B_NEG;
    start = 1'b1;
    tick();
    start = 1'b0;
    data_in_en = 1'b0;
    check("drop.start_err", 80'(drop_err), 80'd1);
    check("drop.start_acc", acc_out, 80'd0);
    for (int b = 0; b < NC; b++) begin
      data_in_en = 1'b1;
      data_in = B_MIX;
      tick();
    end
    data_in = B_NEG;
    tick();
    tick();
    data_in_en = 1'b0;
    wait_valid(2, "drop");
    check("drop.acc", acc_out, A_MIX);
    check("drop.h", 80'(h_out & M_ALL), 80'(4'b1001 & M_ALL));
    data_in_en = 1'b1;
    tick();
    data_in_en = 1'b0;
    tick();
    tick();
    check("drop.idle_acc", acc_out, A_MIX);
    check("drop.sticky", 80'(drop_err), 80'd1);

    // reset mid-pass aborts and clears outputs
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      data_in_en = 1'b1;
      data_in = 64'h0005_0005_0005_0005;
      tick();
    end
    data_in_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.h_out", 80'(h_out), 80'd0);
    check("abort.drop_err", 80'(drop_err), 80'd0);
    check("abort.acc", acc_out, 80'd0);
    check("abort.busy", 80'(busy), 80'd0);
    run_pass(B_ONE, A_ONE, 4'b1111, M_ALL, 0, "fresh");

`ifdef AGS_STOCHASTIC_EN
    for (int r = 0; r < 100; r++)
      run_pass(B_EXT, A_EXT, 4'b0001, 4'b0011, 0, $sformatf("stoch%0d", r));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
